hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_perf_cnt.sv | 30 +++
 rtl/hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the RV32I pipeline hazard controller.
//   - hz_state_e : controller state (RUN, MEM_WAIT, REDIRECT)
//   - reset-value constants for the state, the counters and the perf counters
//   - default parameter values and cnt_w(), which sizes a counter holding 0..max
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } hz_state_e;

  localparam hz_state_e   STATE_RST = RUN;
  localparam int          CNT_RST   = 0;
  localparam logic [31:0] PERF_RST  = 32'd0;

  localparam int DEF_FETCH_LAT   = 1;
  localparam int DEF_MEM_TIMEOUT = 256;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: the two free-running 32-bit performance counters of the
// hazard controller. Both wrap modulo 2^32.
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   stall           PC held this cycle
//   redirect        redirect accepted this cycle
//   stall_cycles    count of cycles with stall = 1
//   redirects       count of accepted redirects
module hazard_perf_cnt
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirects
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= PERF_RST;
      redirects    <= PERF_RST;
    end else begin
      if (stall)    stall_cycles <= stall_cycles + 32'd1;
      if (redirect) redirects    <= redirects + 32'd1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the 5-stage RV32I pipeline.
// Resolves load-use stalls, taken-branch/jump redirects (with a FETCH_LAT
// cycle fetch-redirect window) and multi-cycle data-memory waits (with a
// MEM_TIMEOUT watchdog). Priority: memory freeze > redirect > load-use.
// All control outputs are combinational from inputs and registered state.
//
// Parameters: FETCH_LAT (0..7), MEM_TIMEOUT (2..65535)
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   id_rs1_addr/id_rs2_addr         source registers of the ID instruction
//   id_use_rs1/id_use_rs2           ID instruction actually reads rs1/rs2
//   ex_rd_addr, ex_mem_read         destination / load flag of the EX instruction
//   ex_redirect                     EX resolved a taken branch or jump
//   mem_req, mem_ready              MEM-stage access and its completion
//   pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble,
//   id_ex_flush, ex_mem_hold, mem_wb_bubble   pipeline register controls
//   mem_timeout                     one-cycle watchdog pulse
//   perf_stall_cycles, perf_redirects        performance counters
//
// Build option: define HAZARD_CTRL_PERF_EN to get live perf counters;
// otherwise both perf ports are tied to zero and no counter flops exist.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FETCH_LAT   = DEF_FETCH_LAT,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_hold,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        id_ex_hold,
  output logic        id_ex_bubble,
  output logic        id_ex_flush,
  output logic        ex_mem_hold,
  output logic        mem_wb_bubble,
  output logic        mem_timeout,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_redirects
);

  localparam int REDIR_W = cnt_w(FETCH_LAT);
  localparam int WAIT_W  = cnt_w(MEM_TIMEOUT);

  localparam bit                HAS_WINDOW = (FETCH_LAT > 0);
  localparam logic [REDIR_W-1:0] REDIR_LOAD = REDIR_W'(FETCH_LAT);
  localparam logic [REDIR_W-1:0] REDIR_ONE  = REDIR_W'(1);
  localparam logic [REDIR_W-1:0] REDIR_RST  = REDIR_W'(CNT_RST);
  localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
  // The cycle that takes wait_cnt to MEM_TIMEOUT sees MEM_TIMEOUT-1 registered.
  localparam logic [WAIT_W-1:0]  WAIT_PULSE = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0]  WAIT_RST   = WAIT_W'(CNT_RST);

  hz_state_e          state_q, state_d;
  hz_state_e          ret_q, ret_d;
  logic [REDIR_W-1:0] redir_cnt_q, redir_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;

  logic      freeze;
  logic      load_use;
  logic      redirect_acc;
  logic      wrong_path;
  hz_state_e eff_state;

  assign freeze   = mem_req & ~mem_ready;
  assign load_use = ex_mem_read & (ex_rd_addr != 5'd0) &
                    ((id_use_rs1 & (id_rs1_addr == ex_rd_addr)) |
                     (id_use_rs2 & (id_rs2_addr == ex_rd_addr)));
  assign redirect_acc = ~freeze & ex_redirect;

  // In the release cycle of a memory wait the pipeline behaves as in the
  // state it was in before the wait, so decisions use the saved state.
  assign eff_state  = (state_q == MEM_WAIT) ? ret_q : state_q;
  assign wrong_path = (eff_state == REDIRECT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= STATE_RST;
      ret_q       <= STATE_RST;
      redir_cnt_q <= REDIR_RST;
      wait_cnt_q  <= WAIT_RST;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      redir_cnt_q <= redir_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    redir_cnt_d = redir_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (freeze) begin
      // redir_cnt is left untouched, which pauses the redirect window.
      if (state_q != MEM_WAIT) begin
        ret_d      = state_q;
        state_d    = MEM_WAIT;
        wait_cnt_d = WAIT_ONE;
      end else if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_d = wait_cnt_q + WAIT_ONE;
      end
    end else begin
      ret_d      = RUN;
      wait_cnt_d = WAIT_RST;
      if (redirect_acc && HAS_WINDOW) begin
        state_d     = REDIRECT;
        redir_cnt_d = REDIR_LOAD;
      end else if (wrong_path && (redir_cnt_q != REDIR_ONE)) begin
        state_d     = REDIRECT;
        redir_cnt_d = redir_cnt_q - REDIR_ONE;
      end else begin
        state_d     = RUN;
        redir_cnt_d = REDIR_RST;
      end
    end
  end

  // Output logic
  always_comb begin
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_hold    = 1'b0;
    id_ex_bubble  = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_bubble = 1'b0;
    mem_timeout   = 1'b0;
    if (!rst) begin
      if (freeze) begin
        pc_hold       = 1'b1;
        if_id_hold    = 1'b1;
        id_ex_hold    = 1'b1;
        ex_mem_hold   = 1'b1;
        mem_wb_bubble = 1'b1;
        mem_timeout   = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_PULSE);
      end else begin
        if_id_flush = redirect_acc | wrong_path;
        id_ex_flush = redirect_acc;
        // Load-use only matters on the correct path and without a redirect.
        if (!ex_redirect && !wrong_path && load_use) begin
          pc_hold      = 1'b1;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] redirects_q;

  hazard_perf_cnt u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall        (pc_hold),
    .redirect     (id_ex_flush),
    .stall_cycles (stall_cycles_q),
    .redirects    (redirects_q)
  );

  // Outputs read zero throughout reset, including before the first edge.
  assign perf_stall_cycles = rst ? PERF_RST : stall_cycles_q;
  assign perf_redirects    = rst ? PERF_RST : redirects_q;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_redirects    = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl (FETCH_LAT = 2,
// MEM_TIMEOUT = 8). Directed scenarios followed by random traffic, all
// compared each cycle against a behavioural model that tracks remaining
// wrong-path fetch cycles, the length of the current memory wait and the
// running perf totals.
module tb_hazard_ctrl;

  localparam int FL = 2;
  localparam int MT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic        mem_req, mem_ready;
  logic        pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble;
  logic        id_ex_flush, ex_mem_hold, mem_wb_bubble, mem_timeout;
  logic [31:0] perf_stall_cycles, perf_redirects;

  always #5 clk = ~clk;

  hazard_ctrl #(.FETCH_LAT(FL), .MEM_TIMEOUT(MT)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_rs1_addr       (id_rs1_addr),
    .id_rs2_addr       (id_rs2_addr),
    .id_use_rs1        (id_use_rs1),
    .id_use_rs2        (id_use_rs2),
    .ex_rd_addr        (ex_rd_addr),
    .ex_mem_read       (ex_mem_read),
    .ex_redirect       (ex_redirect),
    .mem_req           (mem_req),
    .mem_ready         (mem_ready),
    .pc_hold           (pc_hold),
    .if_id_hold        (if_id_hold),
    .if_id_flush       (if_id_flush),
    .id_ex_hold        (id_ex_hold),
    .id_ex_bubble      (id_ex_bubble),
    .id_ex_flush       (id_ex_flush),
    .ex_mem_hold       (ex_mem_hold),
    .mem_wb_bubble     (mem_wb_bubble),
    .mem_timeout       (mem_timeout),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_redirects    (perf_redirects)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_flush_left = 0;   // wrong-path fetch cycles still to flush
  int          m_freeze_run = 0;   // frozen cycles so far in the current wait
  logic [31:0] m_stalls     = 32'd0;
  logic [31:0] m_redirs     = 32'd0;

  // Tallies for whole-scenario checks
  int n_flush   = 0;
  int n_timeout = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, compare mid-cycle, advance past the edge, update model.
  task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic mr, input logic rdr, input logic req, input logic rdy);
    logic fr, lu, racc, wp, e_bub, e_stall, e_to, e_iff;
    logic [31:0] e_ps, e_pr;
    rst = r; id_rs1_addr = rs1; id_rs2_addr = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd_addr = rd; ex_mem_read = mr; ex_redirect = rdr; mem_req = req; mem_ready = rdy;
    #2;
    fr      = req && !rdy;
    lu      = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    racc    = !fr && rdr;
    wp      = (m_flush_left > 0);
    e_bub   = !fr && !rdr && !wp && lu;
    e_stall = fr || e_bub;
    e_to    = fr && (m_freeze_run + 1 == MT);
    e_iff   = !fr && (racc || wp);
`ifdef HAZARD_CTRL_PERF_EN
    e_ps = m_stalls; e_pr = m_redirs;
`else
    e_ps = 32'd0; e_pr = 32'd0;
`endif
    if (r) begin
      chk("rst_pc_hold", pc_hold, 0);          chk("rst_if_id_hold", if_id_hold, 0);
      chk("rst_if_id_flush", if_id_flush, 0);  chk("rst_id_ex_hold", id_ex_hold, 0);
      chk("rst_id_ex_bubble", id_ex_bubble, 0); chk("rst_id_ex_flush", id_ex_flush, 0);
      chk("rst_ex_mem_hold", ex_mem_hold, 0);  chk("rst_mem_wb_bubble", mem_wb_bubble, 0);
      chk("rst_mem_timeout", mem_timeout, 0);
      chk("rst_perf_stall", perf_stall_cycles, 0); chk("rst_perf_redir", perf_redirects, 0);
    end else begin
      chk("pc_hold", pc_hold, e_stall);        chk("if_id_hold", if_id_hold, e_stall);
      chk("if_id_flush", if_id_flush, e_iff);  chk("id_ex_hold", id_ex_hold, fr);
      chk("id_ex_bubble", id_ex_bubble, e_bub); chk("id_ex_flush", id_ex_flush, racc);
      chk("ex_mem_hold", ex_mem_hold, fr);     chk("mem_wb_bubble", mem_wb_bubble, fr);
      chk("mem_timeout", mem_timeout, e_to);
      chk("perf_stall_cycles", perf_stall_cycles, e_ps);
      chk("perf_redirects", perf_redirects, e_pr);
    end
    n_flush   += int'(if_id_flush === 1'b1);
    n_timeout += int'(mem_timeout === 1'b1);
    @(posedge clk);
    #1;
    if (r) begin
      m_flush_left = 0; m_freeze_run = 0; m_stalls = 32'd0; m_redirs = 32'd0;
    end else begin
      m_stalls = m_stalls + 32'(e_stall);
      m_redirs = m_redirs + 32'(racc);
      if (fr) begin
        m_freeze_run++;
      end else begin
        m_freeze_run = 0;
        if (racc) m_flush_left = FL;
        else if (m_flush_left > 0) m_flush_left--;
      end
    end
  endtask

  task automatic idle();
    cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with busy inputs: everything must read zero.
    cyc(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();

    // Load-use on rs2, then the load moves on; then rd = x0 gives no stall.
    cyc(1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_bubble_seen_next", 32'(m_stalls), 32'd1);
    cyc(1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd7, 5'd3, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();

    // Redirect pulse: IF/ID flushed for 1 + FETCH_LAT cycles.
    n_flush = 0;
    cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) idle();
    chk("redir_flush_cycles", n_flush, 3);

    // Four-cycle memory wait, released while mem_req is still high.
    repeat (4) cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();

    // Twelve-cycle wait: exactly one timeout pulse.
    n_timeout = 0;
    repeat (12) cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("timeout_pulses", n_timeout, 1);
    idle();

    // Freeze + redirect + load-use together; redirect taken at release.
    n_flush = 0;
    repeat (2) cyc(1'b0, 5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("simul_no_flush_frozen", n_flush, 0);
    cyc(1'b0, 5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) idle();
    chk("simul_flush_after", n_flush, 3);

    // Freeze in the middle of a redirect window pauses it.
    cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 5'd4, 5'd2, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a redirect window.
    cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    cyc(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_flush = 0;
    repeat (2) idle();
    chk("no_residual_flush", n_flush, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic       r, u1, u2, mr, rdr, req, rdy;
      logic [4:0] rs1, rs2, rd;
      r   = ($urandom_range(0, 99) == 0);
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      mr  = ($urandom_range(0, 2) == 0);
      rdr = ($urandom_range(0, 5) == 0);
      req = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 5) == 0);
      cyc(r, rs1, rs2, u1, u2, rd, mr, rdr, req, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
